// File: rtl/ariane_axi_pkg.sv
// Local stand-in for the Ariane AXI4 request/response typedefs used by the IOMMU.
// Field layout follows the usual ariane_axi req_t/resp_t bundling.
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/iommu_axi_arb_pkg.sv
// Shared state encodings and helpers for the IOMMU AXI master arbiter.
package iommu_axi_arb_pkg;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iommu_axi_arb_picker.sv
// Combinational requester picker: round-robin from ptr, or fixed priority from
// index 0 when IOMMU_AXI_ARB_FIXED_PRIO_EN is defined (ptr port then absent).
module iommu_rr_picker #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] valid,
`ifndef IOMMU_AXI_ARB_FIXED_PRIO_EN
  input  logic [IdxW-1:0]   ptr,
`endif
  output logic [IdxW-1:0]   idx,
  output logic              any
);

  int cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < int'(NumReq); k++) begin
`ifdef IOMMU_AXI_ARB_FIXED_PRIO_EN
      cand = k;
`else
      // modulo wrap without a divider so non-power-of-2 counts stay legal
      cand = int'(ptr) + k;
      if (cand >= int'(NumReq)) cand = cand - int'(NumReq);
`endif
      for (int j = 0; j < int'(NumReq); j++) begin
        if (!any && (j == cand) && valid[j]) begin
          any = 1'b1;
          idx = IdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/iommu_axi_arb.sv
// Shares one AXI4 master port between NumReq IOMMU requesters, one locked grant per
// direction. Define IOMMU_AXI_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module iommu_axi_arb
  import iommu_axi_arb_pkg::*;
#(
  parameter int unsigned NumReq = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ariane_axi::req_t  slv_req_i  [NumReq],
  output ariane_axi::resp_t slv_resp_o [NumReq],
  output ariane_axi::req_t  mst_req_o,
  input  ariane_axi::resp_t mst_resp_i,
  output logic              rd_busy_o,
  output logic              wr_busy_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  rd_state_e         rd_state_q, rd_state_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [IdxW-1:0]   rd_gnt_q, rd_gnt_d;
  logic [IdxW-1:0]   wr_gnt_q, wr_gnt_d;
  logic [NumReq-1:0] ar_vld, aw_vld;
  logic [IdxW-1:0]   ar_idx, aw_idx;
  logic              ar_any, aw_any;
  logic              ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      ar_vld[i] = slv_req_i[i].ar_valid;
      aw_vld[i] = slv_req_i[i].aw_valid;
    end
  end

`ifndef IOMMU_AXI_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_rd_ptr, rr_wr_ptr;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] g);
    if (int'(g) >= int'(NumReq) - 1) return '0;
    return g + IdxW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_rd_ptr <= '0;
      rr_wr_ptr <= '0;
    end else begin
      if (r_last_hs) rr_rd_ptr <= next_idx(rd_gnt_q);
      if (b_hs)      rr_wr_ptr <= next_idx(wr_gnt_q);
    end
  end
`endif

  iommu_rr_picker #(.NumReq(NumReq), .IdxW(IdxW)) u_ar_pick (
    .valid (ar_vld),
`ifndef IOMMU_AXI_ARB_FIXED_PRIO_EN
    .ptr   (rr_rd_ptr),
`endif
    .idx   (ar_idx),
    .any   (ar_any)
  );

  iommu_rr_picker #(.NumReq(NumReq), .IdxW(IdxW)) u_aw_pick (
    .valid (aw_vld),
`ifndef IOMMU_AXI_ARB_FIXED_PRIO_EN
    .ptr   (rr_wr_ptr),
`endif
    .idx   (aw_idx),
    .any   (aw_any)
  );

  assign ar_hs     = (rd_state_q == R_AR) && slv_req_i[rd_gnt_q].ar_valid && mst_resp_i.ar_ready;
  assign r_last_hs = (rd_state_q == R_DATA) && mst_resp_i.r_valid &&
                     slv_req_i[rd_gnt_q].r_ready && mst_resp_i.r.last;
  assign aw_hs     = (wr_state_q == W_AW) && slv_req_i[wr_gnt_q].aw_valid && mst_resp_i.aw_ready;
  assign w_last_hs = (wr_state_q == W_DATA) && slv_req_i[wr_gnt_q].w_valid &&
                     mst_resp_i.w_ready && slv_req_i[wr_gnt_q].w.last;
  assign b_hs      = (wr_state_q == W_RESP) && mst_resp_i.b_valid && slv_req_i[wr_gnt_q].b_ready;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    case (rd_state_q)
      R_IDLE: if (ar_any) begin
        rd_gnt_d   = ar_idx;
        rd_state_d = R_AR;
      end
      R_AR:    if (ar_hs)     rd_state_d = R_DATA;
      R_DATA:  if (r_last_hs) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    case (wr_state_q)
      W_IDLE: if (aw_any) begin
        wr_gnt_d   = aw_idx;
        wr_state_d = W_AW;
      end
      W_AW:    if (aw_hs)     wr_state_d = W_DATA;
      W_DATA:  if (w_last_hs) wr_state_d = W_RESP;
      W_RESP:  if (b_hs)      wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_gnt_q   <= '0;
      wr_gnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
    end
  end

  // payloads follow the locked grant; only handshake signals are gated by state
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.ar       = slv_req_i[rd_gnt_q].ar;
    mst_req_o.aw       = slv_req_i[wr_gnt_q].aw;
    mst_req_o.w        = slv_req_i[wr_gnt_q].w;
    mst_req_o.ar_valid = (rd_state_q == R_AR)   && slv_req_i[rd_gnt_q].ar_valid;
    mst_req_o.r_ready  = (rd_state_q == R_DATA) && slv_req_i[rd_gnt_q].r_ready;
    mst_req_o.aw_valid = (wr_state_q == W_AW)   && slv_req_i[wr_gnt_q].aw_valid;
    mst_req_o.w_valid  = (wr_state_q == W_DATA) && slv_req_i[wr_gnt_q].w_valid;
    mst_req_o.b_ready  = (wr_state_q == W_RESP) && slv_req_i[wr_gnt_q].b_ready;
    for (int i = 0; i < int'(NumReq); i++) begin
      slv_resp_o[i]   = '0;
      slv_resp_o[i].r = mst_resp_i.r;
      slv_resp_o[i].b = mst_resp_i.b;
      if (IdxW'(i) == rd_gnt_q) begin
        slv_resp_o[i].ar_ready = (rd_state_q == R_AR)   && mst_resp_i.ar_ready;
        slv_resp_o[i].r_valid  = (rd_state_q == R_DATA) && mst_resp_i.r_valid;
      end
      if (IdxW'(i) == wr_gnt_q) begin
        slv_resp_o[i].aw_ready = (wr_state_q == W_AW)   && mst_resp_i.aw_ready;
        slv_resp_o[i].w_ready  = (wr_state_q == W_DATA) && mst_resp_i.w_ready;
        slv_resp_o[i].b_valid  = (wr_state_q == W_RESP) && mst_resp_i.b_valid;
      end
    end
  end

  assign rd_busy_o = (rd_state_q != R_IDLE);
  assign wr_busy_o = (wr_state_q != W_IDLE);

`ifndef SYNTHESIS
  logic [NumReq-1:0] ar_pend_q, aw_pend_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NumReq); i++) begin
      ar_pend_q[i] <= !rst_i && slv_req_i[i].ar_valid && !slv_resp_o[i].ar_ready;
      aw_pend_q[i] <= !rst_i && slv_req_i[i].aw_valid && !slv_resp_o[i].aw_ready;
      if (!rst_i && ar_pend_q[i])
        assert (slv_req_i[i].ar_valid) else $error("ar_valid dropped before handshake on port %0d", i);
      if (!rst_i && aw_pend_q[i])
        assert (slv_req_i[i].aw_valid) else $error("aw_valid dropped before handshake on port %0d", i);
    end
    if (!rst_i && mst_req_o.aw_valid)
      assert (mst_req_o.aw.atop == '0) else $error("atomic AW forwarded: atop=%0h", mst_req_o.aw.atop);
  end
`endif

endmodule

// File: tb/tb_iommu_axi_arb.sv
// Directed bench for iommu_axi_arb: per-cycle read-path vector table plus
// hand-written write, concurrent and reset-in-burst sequences.
module tb_iommu_axi_arb;

  localparam int NumReq = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  ariane_axi::req_t  slv_req  [NumReq];
  ariane_axi::resp_t slv_resp [NumReq];
  ariane_axi::req_t  mst_req;
  ariane_axi::resp_t mst_resp;
  logic              rd_busy, wr_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iommu_axi_arb #(.NumReq(NumReq)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .rd_busy_o  (rd_busy),
    .wr_busy_o  (wr_busy)
  );

  typedef struct {
    logic       rst;
    logic [2:0] ar_v;
    logic [2:0] sr_rdy;
    logic       m_arrdy;
    logic       m_rv;
    logic       m_rlast;
    logic       e_mar_v;
    logic [3:0] e_id;
    logic [2:0] e_arrdy;
    logic [2:0] e_srv;
    logic       e_mrrdy;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_v, input logic [2:0] arv, input logic [2:0] srr,
                     input logic marr, input logic rv, input logic rl,
                     input logic emv, input logic [3:0] eid, input logic [2:0] earr,
                     input logic [2:0] esrv, input logic emrr, input logic ebusy);
    vec_t v;
    v.rst = rst_v; v.ar_v = arv; v.sr_rdy = srr; v.m_arrdy = marr; v.m_rv = rv;
    v.m_rlast = rl; v.e_mar_v = emv; v.e_id = eid; v.e_arrdy = earr; v.e_srv = esrv;
    v.e_mrrdy = emrr; v.e_busy = ebusy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NumReq; i++) begin
      slv_req[i]         = '0;
      slv_req[i].ar.id   = 4'(i + 1);
      slv_req[i].ar.addr = 64'(i + 1) << 12;
      slv_req[i].ar.len  = (i == 1) ? 8'd3 : 8'd0;
      slv_req[i].aw.id   = 4'(i + 1);
      slv_req[i].aw.addr = 64'(i + 1) << 12;
    end
    mst_resp        = '0;
    mst_resp.r.data = 64'hD0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [2:0] arrdy_vec();
    logic [2:0] r;
    for (int i = 0; i < NumReq; i++) r[i] = slv_resp[i].ar_ready;
    return r;
  endfunction

  function automatic logic [2:0] rvalid_vec();
    logic [2:0] r;
    for (int i = 0; i < NumReq; i++) r[i] = slv_resp[i].r_valid;
    return r;
  endfunction

  initial begin
    // single read by req1, len=3 (4 beats)
    add(0, 3'b010, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b010, 3'b111, 1, 0, 0, 1, 4'd2, 3'b010, 3'b000, 0, 1);
    add(0, 3'b000, 3'b111, 1, 1, 0, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b000, 3'b111, 1, 1, 0, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b000, 3'b111, 1, 1, 0, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b000, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b000, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    // req1 read with 5 cycles of requester backpressure mid-burst
    add(0, 3'b010, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b010, 3'b111, 1, 0, 0, 1, 4'd2, 3'b010, 3'b000, 0, 1);
    add(0, 3'b000, 3'b111, 1, 1, 0, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    for (int k = 0; k < 5; k++)
      add(0, 3'b000, 3'b101, 1, 1, 0, 0, 4'd0, 3'b000, 3'b010, 0, 1);
    add(0, 3'b000, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b000, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(1, 3'b000, 3'b111, 0, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    // three-way contention, single-beat reads
`ifdef IOMMU_AXI_ARB_FIXED_PRIO_EN
    add(0, 3'b111, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b111, 3'b111, 1, 0, 0, 1, 4'd1, 3'b001, 3'b000, 0, 1);
    add(0, 3'b110, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b001, 1, 1);
    add(0, 3'b111, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b111, 3'b111, 1, 0, 0, 1, 4'd1, 3'b001, 3'b000, 0, 1);
    add(0, 3'b110, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b001, 1, 1);
    add(0, 3'b110, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b110, 3'b111, 1, 0, 0, 1, 4'd2, 3'b010, 3'b000, 0, 1);
    add(0, 3'b100, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b100, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b100, 3'b111, 1, 0, 0, 1, 4'd3, 3'b100, 3'b000, 0, 1);
    add(0, 3'b000, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b100, 1, 1);
    add(0, 3'b000, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
`else
    add(0, 3'b111, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b111, 3'b111, 1, 0, 0, 1, 4'd1, 3'b001, 3'b000, 0, 1);
    add(0, 3'b110, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b001, 1, 1);
    add(0, 3'b111, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b111, 3'b111, 1, 0, 0, 1, 4'd2, 3'b010, 3'b000, 0, 1);
    add(0, 3'b101, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b010, 1, 1);
    add(0, 3'b101, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b101, 3'b111, 1, 0, 0, 1, 4'd3, 3'b100, 3'b000, 0, 1);
    add(0, 3'b001, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b100, 1, 1);
    add(0, 3'b001, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b001, 3'b111, 1, 0, 0, 1, 4'd1, 3'b001, 3'b000, 0, 1);
    add(0, 3'b000, 3'b111, 1, 1, 1, 0, 4'd0, 3'b000, 3'b001, 1, 1);
    add(0, 3'b000, 3'b111, 1, 0, 0, 0, 4'd0, 3'b000, 3'b000, 0, 0);
`endif

    // reset state
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst mst_ar_valid", 64'(mst_req.ar_valid), 64'(0));
    chk("rst mst_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    chk("rst mst_w_valid",  64'(mst_req.w_valid),  64'(0));
    chk("rst mst_r_ready",  64'(mst_req.r_ready),  64'(0));
    chk("rst mst_b_ready",  64'(mst_req.b_ready),  64'(0));
    chk("rst rd_busy",      64'(rd_busy),          64'(0));
    chk("rst wr_busy",      64'(wr_busy),          64'(0));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst;
      for (int i = 0; i < NumReq; i++) begin
        slv_req[i].ar_valid = tbl[k].ar_v[i];
        slv_req[i].r_ready  = tbl[k].sr_rdy[i];
      end
      mst_resp.ar_ready = tbl[k].m_arrdy;
      mst_resp.r_valid  = tbl[k].m_rv;
      mst_resp.r.last   = tbl[k].m_rlast;
      #1;
      chk($sformatf("row%0d mst_ar_valid", k), 64'(mst_req.ar_valid), 64'(tbl[k].e_mar_v));
      if (tbl[k].e_mar_v)
        chk($sformatf("row%0d mst_ar_id", k), 64'(mst_req.ar.id), 64'(tbl[k].e_id));
      chk($sformatf("row%0d slv_ar_ready", k), 64'(arrdy_vec()), 64'(tbl[k].e_arrdy));
      chk($sformatf("row%0d slv_r_valid", k), 64'(rvalid_vec()), 64'(tbl[k].e_srv));
      chk($sformatf("row%0d mst_r_ready", k), 64'(mst_req.r_ready), 64'(tbl[k].e_mrrdy));
      chk($sformatf("row%0d rd_busy", k), 64'(rd_busy), 64'(tbl[k].e_busy));
    end

    // write burst from req2: len=1, master w_ready toggles 1,0,1
    do_reset();
    slv_req[2].aw_valid = 1'b1;
    slv_req[2].aw.len   = 8'd1;
    slv_req[2].w_valid  = 1'b1;
    slv_req[2].w.data   = 64'hA0;
    slv_req[2].w.last   = 1'b0;
    slv_req[2].b_ready  = 1'b1;
    mst_resp.aw_ready   = 1'b1;
    mst_resp.w_ready    = 1'b1;
    #1;
    chk("wr idle wr_busy",      64'(wr_busy),              64'(0));
    chk("wr idle mst_aw_valid", 64'(mst_req.aw_valid),     64'(0));
    chk("wr idle slv2 w_ready", 64'(slv_resp[2].w_ready),  64'(0));
    @(negedge clk); #1;
    chk("wr aw mst_aw_valid",   64'(mst_req.aw_valid),     64'(1));
    chk("wr aw mst_aw_id",      64'(mst_req.aw.id),        64'(3));
    chk("wr aw mst_aw_len",     64'(mst_req.aw.len),       64'(1));
    chk("wr aw slv2 aw_ready",  64'(slv_resp[2].aw_ready), 64'(1));
    chk("wr aw slv2 w_ready",   64'(slv_resp[2].w_ready),  64'(0));
    chk("wr aw mst_w_valid",    64'(mst_req.w_valid),      64'(0));
    @(negedge clk);
    slv_req[2].aw_valid = 1'b0;
    #1;
    chk("wr beat0 mst_w_valid", 64'(mst_req.w_valid),      64'(1));
    chk("wr beat0 mst_w_data",  mst_req.w.data,            64'hA0);
    chk("wr beat0 slv2 w_rdy",  64'(slv_resp[2].w_ready),  64'(1));
    chk("wr beat0 slv0 w_rdy",  64'(slv_resp[0].w_ready),  64'(0));
    @(negedge clk);
    slv_req[2].w.data = 64'hB1;
    slv_req[2].w.last = 1'b1;
    mst_resp.w_ready  = 1'b0;
    #1;
    chk("wr stall mst_w_data",  mst_req.w.data,            64'hB1);
    chk("wr stall slv2 w_rdy",  64'(slv_resp[2].w_ready),  64'(0));
    @(negedge clk);
    mst_resp.w_ready = 1'b1;
    #1;
    chk("wr beat1 slv2 w_rdy",  64'(slv_resp[2].w_ready),  64'(1));
    chk("wr beat1 mst_w_last",  64'(mst_req.w.last),       64'(1));
    @(negedge clk);
    slv_req[2].w_valid = 1'b0;
    slv_req[0].b_ready = 1'b1;
    slv_req[1].b_ready = 1'b1;
    mst_resp.b_valid   = 1'b1;
    mst_resp.b.id      = 4'd3;
    mst_resp.b.resp    = 2'b00;
    #1;
    chk("wr b slv2 b_valid",    64'(slv_resp[2].b_valid),  64'(1));
    chk("wr b slv0 b_valid",    64'(slv_resp[0].b_valid),  64'(0));
    chk("wr b slv1 b_valid",    64'(slv_resp[1].b_valid),  64'(0));
    chk("wr b slv2 b_resp",     64'(slv_resp[2].b.resp),   64'(0));
    chk("wr b mst_b_ready",     64'(mst_req.b_ready),      64'(1));
    chk("wr b wr_busy",         64'(wr_busy),              64'(1));
    @(negedge clk);
    mst_resp.b_valid = 1'b0;
    #1;
    chk("wr done wr_busy",      64'(wr_busy),              64'(0));

    // concurrent write from req0 and read from req1
    do_reset();
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].w_valid  = 1'b1;
    slv_req[0].w.data   = 64'h55;
    slv_req[0].w.last   = 1'b1;
    slv_req[0].b_ready  = 1'b1;
    slv_req[1].ar_valid = 1'b1;
    slv_req[1].r_ready  = 1'b1;
    mst_resp.aw_ready   = 1'b1;
    mst_resp.ar_ready   = 1'b1;
    mst_resp.w_ready    = 1'b1;
    @(negedge clk); #1;
    chk("cc mst_ar_valid",      64'(mst_req.ar_valid),     64'(1));
    chk("cc mst_aw_valid",      64'(mst_req.aw_valid),     64'(1));
    chk("cc mst_ar_id",         64'(mst_req.ar.id),        64'(2));
    chk("cc mst_ar_addr",       mst_req.ar.addr,           64'h2000);
    chk("cc mst_aw_id",         64'(mst_req.aw.id),        64'(1));
    @(negedge clk);
    slv_req[0].aw_valid = 1'b0;
    slv_req[1].ar_valid = 1'b0;
    mst_resp.r_valid    = 1'b1;
    mst_resp.r.last     = 1'b1;
    #1;
    chk("cc slv1 r_valid",      64'(slv_resp[1].r_valid),  64'(1));
    chk("cc slv0 r_valid",      64'(slv_resp[0].r_valid),  64'(0));
    chk("cc slv1 r_data",       slv_resp[1].r.data,        64'hD0);
    chk("cc mst_w_valid",       64'(mst_req.w_valid),      64'(1));
    chk("cc mst_w_data",        mst_req.w.data,            64'h55);
    @(negedge clk);
    mst_resp.r_valid   = 1'b0;
    slv_req[0].w_valid = 1'b0;
    mst_resp.b_valid   = 1'b1;
    mst_resp.b.id      = 4'd1;
    #1;
    chk("cc rd_busy",           64'(rd_busy),              64'(0));
    chk("cc wr_busy",           64'(wr_busy),              64'(1));
    chk("cc slv0 b_valid",      64'(slv_resp[0].b_valid),  64'(1));
    chk("cc slv1 b_valid",      64'(slv_resp[1].b_valid),  64'(0));
    @(negedge clk);
    mst_resp.b_valid = 1'b0;
    #1;
    chk("cc done wr_busy",      64'(wr_busy),              64'(0));

    // reset during R_DATA; pointer must return to 0
    do_reset();
    slv_req[1].ar_valid = 1'b1;
    slv_req[1].r_ready  = 1'b1;
    mst_resp.ar_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    slv_req[1].ar_valid = 1'b0;
    mst_resp.r_valid    = 1'b1;
    mst_resp.r.last     = 1'b1;
    @(negedge clk);
    mst_resp.r_valid    = 1'b0;
    slv_req[1].ar_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    slv_req[1].ar_valid = 1'b0;
    mst_resp.r_valid    = 1'b1;
    mst_resp.r.last     = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstd pre rd_busy",     64'(rd_busy),              64'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstd rd_busy",         64'(rd_busy),              64'(0));
    chk("rstd mst_ar_valid",    64'(mst_req.ar_valid),     64'(0));
    chk("rstd mst_r_ready",     64'(mst_req.r_ready),      64'(0));
    chk("rstd slv1 r_valid",    64'(slv_resp[1].r_valid),  64'(0));
    chk("rstd slv1 ar_ready",   64'(slv_resp[1].ar_ready), 64'(0));
    mst_resp.r_valid    = 1'b0;
    slv_req[0].ar_valid = 1'b1;
    slv_req[2].ar_valid = 1'b1;
    @(negedge clk); #1;
    chk("rstd ptr mst_ar_valid", 64'(mst_req.ar_valid),    64'(1));
    chk("rstd ptr mst_ar_id",    64'(mst_req.ar.id),       64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
